serial_to_parallel_4bits: RTL and testbench

//  Upstream stage of the 4-bit parallel shift register: collects a serial bit

---
 rtl/serial_to_parallel_4bits.sv | 88 ++++++++
 tb/tb_serial_to_parallel_4bits.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_4bits.sv
// rtl/serial_to_parallel_4bits.sv - serial bit collector feeding a WIDTH-bit holding register
module serial_to_parallel_4bits #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_sync,
    output logic             sin_ready,
    output logic [WIDTH-1:0] D_out,
    output logic [WIDTH-1:0] D_outbar,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       bit_cnt
);

    typedef enum logic {HOLD_EMPTY = 1'b0, HOLD_FULL = 1'b1} hold_state_t;

    localparam logic [3:0] LAST_CNT = 4'(WIDTH - 1);

    hold_state_t      state_q;
    hold_state_t      state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] hold_q;
    logic [3:0]       cnt_q;
    logic             at_last;
    logic             accept;
    logic             complete;
    logic             take;

    // Only the word-completing bit can stall, and only if the held word is not leaving now.
    assign at_last   = (cnt_q == LAST_CNT);
    assign sin_ready = ~(at_last & (state_q == HOLD_FULL) & ~out_ready);
    assign accept    = sin_valid & sin_ready;
    assign complete  = accept & ~sin_sync & at_last;
    assign take      = (state_q == HOLD_FULL) & out_ready;

    always_comb begin
        shift_d = shift_q;
        if (sin_sync) begin
            if (MSB_FIRST) shift_d = {{(WIDTH-1){1'b0}}, sin};
            else           shift_d = {sin, {(WIDTH-1){1'b0}}};
        end else begin
            if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], sin};
            else           shift_d = {sin, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else if (accept) begin
            shift_q <= shift_d;
            if (sin_sync)      cnt_q <= 4'd1;
            else if (complete) cnt_q <= 4'd0;
            else               cnt_q <= cnt_q + 4'd1;
            if (complete) hold_q <= shift_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= HOLD_EMPTY;
        else      state_q <= state_d;
    end

    // A completing word refills the holding stage even while the old one is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD_EMPTY: if (complete)         state_d = HOLD_FULL;
            HOLD_FULL:  if (take & ~complete) state_d = HOLD_EMPTY;
            default:                          state_d = HOLD_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == HOLD_FULL);
        D_out     = hold_q;
        D_outbar  = ~hold_q;
        bit_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_serial_to_parallel_4bits.sv
// tb/tb_serial_to_parallel_4bits.sv - directed bench for serial_to_parallel_4bits
module tb_serial_to_parallel_4bits;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       sin_sync;
    logic       out_ready;
    logic       sin_ready0, sin_ready1;
    logic [3:0] d_out0, d_out1;
    logic [3:0] d_outbar0, d_outbar1;
    logic       out_valid0, out_valid1;
    logic [3:0] bit_cnt0, bit_cnt1;
    int         tests;
    int         failed;

    serial_to_parallel_4bits #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sync(sin_sync),
        .sin_ready(sin_ready0), .D_out(d_out0), .D_outbar(d_outbar0),
        .out_valid(out_valid0), .out_ready(out_ready), .bit_cnt(bit_cnt0)
    );

    serial_to_parallel_4bits #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sync(sin_sync),
        .sin_ready(sin_ready1), .D_out(d_out1), .D_outbar(d_outbar1),
        .out_valid(out_valid1), .out_ready(out_ready), .bit_cnt(bit_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic s);
        sin_valid = v;
        sin       = b;
        sin_sync  = s;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_sync  = 1'b0;
    endtask

    task automatic send4(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) step(1'b1, w[i], 1'b0);
    endtask

    initial begin
        logic [7:0] stream;
        tests     = 0;
        failed    = 0;
        rst       = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        sin_sync  = 1'b0;
        out_ready = 1'b1;

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", d_out0, 4'h0);
        check("rst_doutbar", d_outbar0, 4'hf);
        check("rst_doutbar_lsb", d_outbar1, 4'hf);
        check("rst_valid", out_valid0, 1'b0);
        check("rst_cnt", bit_cnt0, 4'd0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("rel_ready", sin_ready0, 1'b1);

        // 2. basic word, valid for exactly one cycle
        send4(4'b1010);
        check("basic_dout", d_out0, 4'b1010);
        check("basic_valid", out_valid0, 1'b1);
        check("basic_bar", d_outbar0, 4'b0101);
        step(1'b0, 1'b0, 1'b0);
        check("basic_taken", out_valid0, 1'b0);
        check("basic_hold", d_out0, 4'b1010);

        // 3. back-to-back words without a stall
        stream = 8'b1010_1110;
        for (int i = 7; i >= 0; i--) begin
            check("b2b_ready", sin_ready0, 1'b1);
            step(1'b1, stream[i], 1'b0);
            if (i == 4) check("b2b_first", d_out0, 4'b1010);
        end
        check("b2b_second", d_out0, 4'b1110);
        check("b2b_valid", out_valid0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // 4. backpressure
        out_ready = 1'b0;
        send4(4'b1011);
        check("bp_word", d_out0, 4'b1011);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("bp_cnt", bit_cnt0, 4'd3);
        check("bp_ready", sin_ready0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("bp_noaccept", bit_cnt0, 4'd3);
        check("bp_held", d_out0, 4'b1011);
        check("bp_held_valid", out_valid0, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", sin_ready0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("bp_new", d_out0, 4'b1111);
        check("bp_nobubble", out_valid0, 1'b1);
        check("bp_cnt_wrap", bit_cnt0, 4'd0);
        step(1'b0, 1'b0, 1'b0);
        check("bp_drain", out_valid0, 1'b0);

        // 5. sync discards partial word
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("sync_cnt", bit_cnt0, 4'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("sync_dout", d_out0, 4'b1001);
        check("sync_dout_lsb", d_out1, 4'b1001);
        step(1'b0, 1'b0, 1'b0);

        // 6. asynchronous reset mid-word
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("mid_cnt", bit_cnt0, 4'd2);
        #3;
        rst = 1'b0;
        #1;
        check("arst_dout", d_out0, 4'h0);
        check("arst_bar", d_outbar0, 4'hf);
        check("arst_cnt", bit_cnt0, 4'd0);
        check("arst_valid", out_valid0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send4(4'b1001);
        check("post_dout", d_out0, 4'b1001);
        check("post_dout_lsb", d_out1, 4'b1001);
        check("post_valid", out_valid0, 1'b1);
        send4(4'b1000);
        check("msb_1000", d_out0, 4'b1000);
        check("lsb_0001", d_out1, 4'b0001);
        check("lsb_bar", d_outbar1, 4'b1110);
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
